// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
// - slot_t      : one tracked in-flight instruction (EX and later stages).
// - REG_ZERO    : the hard-wired zero register, never a forwarding/hazard source.
// - FWD_*       : forwarding-select encoding (0 = register file, k = k stages after EX).
// - slot_writes : true when a slot will write register r (x0 excluded).
package pipe_pkg;

    // Register fields are stored at a fixed maximum width; narrower builds zero-extend.
    localparam int unsigned REG_ADDR_W_MAX = 8;

    localparam logic [REG_ADDR_W_MAX-1:0] REG_ZERO = '0;

    localparam int unsigned FWD_RF  = 0;
    localparam int unsigned FWD_MEM = 1;
    localparam int unsigned FWD_WB  = 2;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_W_MAX-1:0] rd;
        logic                      wr;
        logic                      load;
        logic [REG_ADDR_W_MAX-1:0] rs1;
        logic [REG_ADDR_W_MAX-1:0] rs2;
        logic                      use_rs1;
        logic                      use_rs2;
    } slot_t;

    function automatic logic slot_writes(input slot_t s, input logic [REG_ADDR_W_MAX-1:0] r);
        return s.valid && s.wr && (s.rd == r) && (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding priority encoder for one EX operand.
// Ports:
//   src_i     : EX operand source register (zero-extended)
//   use_src_i : EX instruction actually reads src_i
//   prod_i    : tracker slots 1..NUM_FWD (prod_i[0] is the stage right after EX)
//   sel_o     : 0 = register file, k = forward from stage k after EX
// The youngest producer (smallest k) wins.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_FWD   = 2,
    parameter int unsigned FWD_SEL_W = 2
) (
    input  logic [REG_ADDR_W_MAX-1:0] src_i,
    input  logic                      use_src_i,
    input  slot_t                     prod_i [NUM_FWD],
    output logic [FWD_SEL_W-1:0]      sel_o
);

    always_comb begin
        sel_o = FWD_SEL_W'(FWD_RF);
        if (use_src_i) begin
            // Scan oldest to youngest so the youngest match overwrites.
            for (int k = NUM_FWD; k >= 1; k--) begin
                if (slot_writes(prod_i[k-1], src_i)) begin
                    sel_o = FWD_SEL_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard detection and forwarding control for the in-order RISC-V pipeline.
// Tracks instructions from EX through NUM_FWD later stages and produces stalls
// (load-use, branch operand), IF/ID flush on a taken branch, EX forwarding selects
// and a whole-pipeline freeze while the data memory is busy.
// Ports:
//   clk_i, rst_i (synchronous, active-low)
//   id_*_i      : decoded ID-stage instruction information
//   br_taken_i  : ID branch resolved taken
//   mem_busy_i  : data memory not ready, freeze everything
//   pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, freeze_o : buffer controls
//   fwd_a_o, fwd_b_o : EX operand selects (0 = register file, k = k stages after EX)
// Optional (macro PIPE_HAZARD_PERF_EN): saturating 32-bit stall/flush/freeze cycle counters.
// All outputs are forced to 0 while rst_i is low.
module pipe_hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter  int unsigned REG_ADDR_W = 5,
    parameter  int unsigned NUM_FWD    = 2,
    localparam int unsigned FWD_SEL_W  = $clog2(NUM_FWD + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_wr_i,
    input  logic                  id_load_i,
    input  logic                  id_branch_i,
    input  logic                  br_taken_i,
    input  logic                  mem_busy_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  idex_bubble_o,
    output logic                  freeze_o,
    output logic [FWD_SEL_W-1:0]  fwd_a_o,
    output logic [FWD_SEL_W-1:0]  fwd_b_o
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           flush_cnt_o,
    output logic [31:0]           freeze_cnt_o
`endif
);

    if (NUM_FWD < 1 || NUM_FWD > 4) begin : g_bad_num_fwd
        $error("NUM_FWD must be in 1..4");
    end
    if (REG_ADDR_W > REG_ADDR_W_MAX) begin : g_bad_reg_w
        $error("REG_ADDR_W exceeds REG_ADDR_W_MAX");
    end

    slot_t slot_q [NUM_FWD+1];
    slot_t slot_d [NUM_FWD+1];
    slot_t prod   [NUM_FWD];
    slot_t id_slot;

    logic hit0, hit1;
    logic stall, freeze, flush;
    logic [FWD_SEL_W-1:0] fwd_a, fwd_b;

    // Capture the ID instruction in tracker format.
    always_comb begin
        id_slot                          = '0;
        id_slot.valid                    = id_valid_i;
        id_slot.rd[REG_ADDR_W-1:0]       = id_rd_i;
        id_slot.wr                       = id_wr_i;
        id_slot.load                     = id_load_i;
        id_slot.rs1[REG_ADDR_W-1:0]      = id_rs1_i;
        id_slot.rs2[REG_ADDR_W-1:0]      = id_rs2_i;
        id_slot.use_rs1                  = id_use_rs1_i;
        id_slot.use_rs2                  = id_use_rs2_i;
    end

    // Does a tracked producer feed a source the ID instruction actually reads?
    always_comb begin
        hit0 = (id_use_rs1_i && slot_writes(slot_q[0], id_slot.rs1)) ||
               (id_use_rs2_i && slot_writes(slot_q[0], id_slot.rs2));
        hit1 = (id_use_rs1_i && slot_writes(slot_q[1], id_slot.rs1)) ||
               (id_use_rs2_i && slot_writes(slot_q[1], id_slot.rs2));
    end

    always_comb begin
        freeze = mem_busy_i;
        stall  = id_valid_i &&
                 ((slot_q[0].load && hit0) ||
                  (id_branch_i && (hit0 || (slot_q[1].load && hit1))));
        flush  = !freeze && !stall && br_taken_i && id_branch_i;
    end

    // Tracker next state: hold on freeze, otherwise shift; a stall injects a bubble.
    always_comb begin
        slot_d = slot_q;
        if (!freeze) begin
            for (int k = NUM_FWD; k >= 1; k--) begin
                slot_d[k] = slot_q[k-1];
            end
            slot_d[0] = stall ? '0 : id_slot;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k <= NUM_FWD; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            slot_q <= slot_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_FWD; k++) begin
            prod[k] = slot_q[k+1];
        end
    end

    fwd_select #(
        .NUM_FWD   (NUM_FWD),
        .FWD_SEL_W (FWD_SEL_W)
    ) u_fwd_a (
        .src_i     (slot_q[0].rs1),
        .use_src_i (slot_q[0].use_rs1),
        .prod_i    (prod),
        .sel_o     (fwd_a)
    );

    fwd_select #(
        .NUM_FWD   (NUM_FWD),
        .FWD_SEL_W (FWD_SEL_W)
    ) u_fwd_b (
        .src_i     (slot_q[0].rs2),
        .use_src_i (slot_q[0].use_rs2),
        .prod_i    (prod),
        .sel_o     (fwd_b)
    );

    always_comb begin
        pc_write_o    = rst_i && !freeze && !stall;
        ifid_write_o  = rst_i && !freeze && !stall;
        ifid_flush_o  = rst_i && flush;
        idex_bubble_o = rst_i && !freeze && stall;
        freeze_o      = rst_i && freeze;
        fwd_a_o       = rst_i ? fwd_a : '0;
        fwd_b_o       = rst_i ? fwd_b : '0;
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

    // Stall counts only cycles where the bubble is actually inserted (not frozen).
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (!freeze && stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
            if (freeze && (freeze_cnt_q != '1)) begin
                freeze_cnt_q <= freeze_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        stall_cnt_o  = rst_i ? stall_cnt_q  : '0;
        flush_cnt_o  = rst_i ? flush_cnt_q  : '0;
        freeze_cnt_o = rst_i ? freeze_cnt_q : '0;
    end
`endif

endmodule
